// File: rtl/bnn_seq_classifier.sv
// ----------------------------------------------------------------------------
// bnn_seq_classifier: time-multiplexed single-hidden-layer XNOR-popcount BNN
// with per-class score accumulation and a sequential argmax.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bnn_seq_classifier #(
  parameter int FEAT_CNT   = 16,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 10,
  parameter int LANES      = 4,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [FEAT_CNT*FEAT_BITS-1:0]                       features,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [((CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1)-1:0] prediction,
  output logic [$clog2(HIDDEN_CNT+1)-1:0]                     score_max
);

  localparam int H   = (HIDDEN_CNT + LANES - 1) / LANES;
  localparam int SW  = $clog2(HIDDEN_CNT + 1);
  localparam int CW  = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
  localparam int STW = (H > 1) ? $clog2(H) : 1;
  localparam int NW  = FEAT_BITS + $clog2(FEAT_CNT) + 1;
  localparam int W1W = HIDDEN_CNT * FEAT_CNT;
  localparam int W2W = CLASS_CNT * HIDDEN_CNT;
  localparam int FW  = FEAT_CNT * FEAT_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HID  = 2'd1,
    S_ARG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                        state_q;
  logic [STW-1:0]                step_q;
  logic [CW-1:0]                 cls_q;
  logic [FW-1:0]                 feat_q;
  logic [CLASS_CNT-1:0][SW-1:0]  score_q;
  logic [CLASS_CNT-1:0][SW-1:0]  score_d;
  logic [CW-1:0]                 best_idx_q;
  logic [SW-1:0]                 best_score_q;
  logic [CW-1:0]                 best_idx_d;
  logic [SW-1:0]                 best_score_d;
  logic [CW-1:0]                 pred_q;
  logic [SW-1:0]                 score_max_q;
  logic                          out_valid_q;

  logic                          accept_w;
  logic [31:0]                   lane_idx_w [LANES];
  logic [LANES-1:0]              lane_en_w;
  logic [LANES-1:0]              lane_hid_w;
  logic [SW-1:0]                 cls_score_w;
  logic                          take_w;

  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept_w   = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign prediction = pred_q;
  assign score_max  = score_max_q;

  // Hidden neuron evaluation; weight bits are picked by shifting so a lane
  // past HIDDEN_CNT simply reads zeros and is then masked by lane_en_w.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [NW-1:0]        sum_w;
    logic [FEAT_BITS-1:0] x_w;

    assign lane_idx_w[l] = 32'(step_q) * 32'(LANES) + 32'(l);
    assign lane_en_w[l]  = (lane_idx_w[l] < 32'(HIDDEN_CNT));

    always_comb begin
      sum_w = '0;
      x_w   = '0;
      for (int k = 0; k < FEAT_CNT; k++) begin
        x_w = FEAT_BITS'(feat_q >> (k * FEAT_BITS));
        if (|(W1 & (W1W'(1) << (lane_idx_w[l] * 32'(FEAT_CNT) + 32'(k)))))
          sum_w = sum_w + NW'(x_w);
        else
          sum_w = sum_w - NW'(x_w);
      end
    end

    assign lane_hid_w[l] = ~sum_w[NW-1];
  end

  for (genvar c = 0; c < CLASS_CNT; c++) begin : g_cls
    logic [LANES-1:0] match_w;

    for (genvar l = 0; l < LANES; l++) begin : g_match
      logic w2_bit;
      assign w2_bit     = |(W2 & (W2W'(1) << (32'(c * HIDDEN_CNT) + lane_idx_w[l])));
      assign match_w[l] = lane_en_w[l] & ~(lane_hid_w[l] ^ w2_bit);
    end

    assign score_d[c] = score_q[c] + SW'($countones(match_w));
  end

  // Strict greater-than keeps the lowest index on ties.
  assign cls_score_w  = score_q[cls_q];
  assign take_w       = (cls_q == '0) || (cls_score_w > best_score_q);
  assign best_idx_d   = take_w ? cls_q : best_idx_q;
  assign best_score_d = take_w ? cls_score_w : best_score_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      cls_q        <= '0;
      feat_q       <= '0;
      score_q      <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      pred_q       <= '0;
      score_max_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      if ((state_q == S_DONE) && out_ready)
        out_valid_q <= 1'b0;

      if (accept_w) begin
        feat_q  <= features;
        score_q <= '0;
        step_q  <= '0;
        state_q <= S_HID;
      end else begin
        case (state_q)
          S_HID: begin
            score_q <= score_d;
            if (step_q == STW'(H - 1)) begin
              cls_q        <= '0;
              best_idx_q   <= '0;
              best_score_q <= '0;
              state_q      <= S_ARG;
            end else begin
              step_q <= step_q + STW'(1);
            end
          end
          S_ARG: begin
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            if (cls_q == CW'(CLASS_CNT - 1)) begin
              pred_q      <= best_idx_d;
              score_max_q <= best_score_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              cls_q <= cls_q + CW'(1);
            end
          end
          S_DONE: begin
            if (out_ready)
              state_q <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
